// File: rtl/sram_arbiter.sv
// Two-port arbiter for a single async SRAM: buffered UART writes and priority VGA reads.
// A read-streak limit bounds how long a pending write can be starved.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned MAX_RD_STREAK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    localparam int unsigned CntW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int unsigned StreakW = $clog2(MAX_RD_STREAK + 1);
    localparam logic [CntW-1:0]    LastCnt   = CntW'(ACCESS_CYCLES - 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_RD_STREAK);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StTurn} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                buf_full_q, buf_full_d;
    logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0]   buf_data_q, buf_data_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dq_q, dq_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic last_cyc, decide, wr_pend, grant_rd, grant_wr;

    assign last_cyc = (state_q == StRd || state_q == StWr) && (cnt_q == LastCnt);
    assign decide   = (state_q == StIdle) || (state_q == StTurn) || last_cyc;
    // The buffer being written out right now no longer counts as pending.
    assign wr_pend  = buf_full_q && (state_q != StWr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (decide) begin
            cnt_d = '0;
            if (wr_pend && (streak_q >= StreakMax || !rd_req)) begin
                state_d  = StWr;
                grant_wr = 1'b1;
            end else if (rd_req) begin
                if (state_q == StWr) begin
                    state_d = StTurn;
                end else begin
                    state_d  = StRd;
                    grant_rd = 1'b1;
                end
            end else if (wr_pend) begin
                state_d  = StWr;
                grant_wr = 1'b1;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_q)
            StRd: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_ub_n = 1'b0;
            end
            StWr: begin
                sram_ce_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_dq_oe = 1'b1;
                // we_n rises one cycle early so data is held past the write edge.
                sram_we_n  = last_cyc;
            end
            default: ;
        endcase
    end

    always_comb begin
        streak_d   = streak_q;
        addr_d     = addr_q;
        dq_d       = dq_q;
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        if (grant_wr) begin
            streak_d = '0;
            addr_d   = buf_addr_q;
            dq_d     = buf_data_q;
        end
        if (grant_rd) begin
            addr_d = rd_addr;
            if (streak_q < StreakMax) begin
                streak_d = streak_q + StreakW'(1);
            end
        end
        if (state_q == StWr && last_cyc) begin
            buf_full_d = 1'b0;
        end else if (wr_req && !buf_full_q) begin
            buf_full_d = 1'b1;
            buf_addr_d = wr_addr;
            buf_data_d = wr_data;
        end
        if (state_q == StRd && last_cyc) begin
            rd_valid_d = 1'b1;
            rd_data_d  = sram_dq_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q   <= '0;
            buf_full_q <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            addr_q     <= '0;
            dq_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            streak_q   <= streak_d;
            buf_full_q <= buf_full_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            addr_q     <= addr_d;
            dq_q       <= dq_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_ready  = ~buf_full_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign sram_addr = addr_q;
    assign sram_dq_o = dq_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: access-plan model checked every cycle, plus directed literal checks.
module tb_sram_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int AC = 2;
    localparam int MAX_RD = 8;
    localparam logic [1:0] K_IDLE = 2'd0, K_RD = 2'd1, K_WR = 2'd2, K_TURN = 2'd3;

    logic clk, rst_n;
    logic wr_req, wr_ready, rd_req, rd_valid;
    logic [AW-1:0] wr_addr, rd_addr, sram_addr;
    logic [DW-1:0] wr_data, rd_data, sram_dq_o, sram_dq_i;
    logic sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    int n_checks = 0;
    int n_errors = 0;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC), .MAX_RD_STREAK(MAX_RD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Async SRAM stand-in: write on any clock edge seen with ce_n and we_n low.
    logic [DW-1:0] sram_mem [0:31];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[4:0]] : 16'hDEAD;
    initial begin
        for (int i = 0; i < 32; i++) sram_mem[i] = DW'(16'h1000 + i);
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr[4:0]] <= sram_dq_o;
        end
    end

    // Model: a queue of planned bus cycles, refilled whenever the plan runs dry.
    typedef struct packed {
        logic [1:0]    kind;
        logic          last;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } slot_t;

    slot_t         plan[$];
    slot_t         cur;
    slot_t         idle_slot;
    logic          m_pending, m_wlock, m_valid;
    logic [AW-1:0] m_baddr;
    logic [DW-1:0] m_bdata, m_rdata;
    int            m_streak;
    logic [DW-1:0] ref_mem [0:31];

    task automatic model_reset();
        plan.delete();
        cur       = idle_slot;
        m_pending = 1'b0;
        m_wlock   = 1'b0;
        m_valid   = 1'b0;
        m_rdata   = '0;
        m_streak  = 0;
    endtask

    task automatic model_step();
        slot_t s;
        logic  load_now;
        if (plan.size() == 0) begin
            if (m_pending && (m_streak >= MAX_RD || !rd_req)) begin
                for (int i = 0; i < AC; i++) begin
                    s.kind = K_WR; s.last = (i == AC - 1); s.addr = m_baddr; s.data = m_bdata;
                    plan.push_back(s);
                end
                m_pending = 1'b0;
                m_streak  = 0;
            end else if (rd_req) begin
                if (cur.kind == K_WR) begin
                    s.kind = K_TURN; s.last = 1'b1; s.addr = '0; s.data = '0;
                    plan.push_back(s);
                end else begin
                    for (int i = 0; i < AC; i++) begin
                        s.kind = K_RD; s.last = (i == AC - 1); s.addr = rd_addr; s.data = '0;
                        plan.push_back(s);
                    end
                    if (m_streak < MAX_RD) m_streak++;
                end
            end
        end
        load_now = wr_req && !m_wlock;
        m_valid  = 1'b0;
        if (cur.kind == K_RD && cur.last) begin
            m_valid = 1'b1;
            m_rdata = ref_mem[cur.addr[4:0]];
        end
        if (cur.kind == K_WR && cur.last) begin
            ref_mem[cur.addr[4:0]] = cur.data;
            m_wlock = 1'b0;
        end
        if (load_now) begin
            m_pending = 1'b1;
            m_wlock   = 1'b1;
            m_baddr   = wr_addr;
            m_bdata   = wr_data;
        end
        cur = (plan.size() != 0) ? plan.pop_front() : idle_slot;
    endtask

    initial begin
        idle_slot = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = DW'(16'h1000 + i);
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        logic busy;
        forever begin
            @(negedge clk);
            busy = (cur.kind == K_RD) || (cur.kind == K_WR);
            check("cmp_ce_n", 32'(sram_ce_n), busy ? 0 : 1);
            check("cmp_lb_n", 32'(sram_lb_n), busy ? 0 : 1);
            check("cmp_ub_n", 32'(sram_ub_n), busy ? 0 : 1);
            check("cmp_oe_n", 32'(sram_oe_n), (cur.kind == K_RD) ? 0 : 1);
            check("cmp_we_n", 32'(sram_we_n), (cur.kind == K_WR && !cur.last) ? 0 : 1);
            check("cmp_dq_oe", 32'(sram_dq_oe), (cur.kind == K_WR) ? 1 : 0);
            if (busy) check("cmp_addr", 32'(sram_addr), 32'(cur.addr));
            if (cur.kind == K_WR) check("cmp_dq_o", 32'(sram_dq_o), 32'(cur.data));
            check("cmp_wr_ready", 32'(wr_ready), m_wlock ? 0 : 1);
            check("cmp_rd_valid", 32'(rd_valid), 32'(m_valid));
            check("cmp_rd_data", 32'(rd_data), 32'(m_rdata));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nvalid;
        rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #5;
        check("rst_wr_ready", 32'(wr_ready), 1);
        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_dq_oe", 32'(sram_dq_oe), 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_dq_o", 32'(sram_dq_o), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        cyc(); rst_n = 1'b1;

        // Write 5 <- 0x0ABC, then read it back across the WR->RD turnaround.
        cyc(); wr_req = 1'b1; wr_addr = 5; wr_data = 16'h0ABC;
        cyc(); wr_req = 1'b0; #4;
        check("t1_wr_ready_c1", 32'(wr_ready), 0);
        cyc(); rd_req = 1'b1; rd_addr = 5; #4;
        check("t1_we_n_c2", 32'(sram_we_n), 0);
        check("t1_addr_c2", 32'(sram_addr), 5);
        check("t1_dq_c2", 32'(sram_dq_o), 32'h0ABC);
        check("t1_dq_oe_c2", 32'(sram_dq_oe), 1);
        cyc(); #4;
        check("t1_we_n_c3", 32'(sram_we_n), 1);
        check("t1_dq_oe_c3", 32'(sram_dq_oe), 1);
        cyc(); #4;
        check("t1_wr_ready_c4", 32'(wr_ready), 1);
        check("t2_turn_ce_n", 32'(sram_ce_n), 1);
        check("t2_turn_dq_oe", 32'(sram_dq_oe), 0);
        cyc(); rd_req = 1'b0; #4;
        check("t2_rd_oe_n_c5", 32'(sram_oe_n), 0);
        cyc(); #4;
        cyc(); #4;
        check("t2_rd_valid_c7", 32'(rd_valid), 1);
        check("t2_rd_data_c7", 32'(rd_data), 32'h0ABC);
        cyc(); #4;
        check("t2_rd_valid_c8", 32'(rd_valid), 0);
        check("t2_rd_hold_c8", 32'(rd_data), 32'h0ABC);

        // Simultaneous read and write from idle: read first, write right behind.
        cyc(); rd_req = 1'b1; rd_addr = 7; wr_req = 1'b1; wr_addr = 9; wr_data = 16'h5A5A;
        cyc(); rd_req = 1'b0; wr_req = 1'b0; #4;
        check("t3_rd_first", 32'(sram_oe_n), 0);
        check("t3_rd_addr", 32'(sram_addr), 7);
        cyc(); #4;
        cyc(); #4;
        check("t3_wr_next", 32'(sram_we_n), 0);
        check("t3_wr_addr", 32'(sram_addr), 9);
        check("t3_rd_data", 32'(rd_data), 32'h1007);
        cyc(); #4;
        cyc(); #4;
        check("t3_idle_ce_n", 32'(sram_ce_n), 1);

        // Held read stream with a write pending: 8 reads, one write, reads resume.
        cyc(); rd_req = 1'b1; rd_addr = 3; wr_req = 1'b1; wr_addr = 10; wr_data = 16'hBEEF;
        nvalid = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            wr_req = 1'b0;
            if (k == 20) begin wr_req = 1'b1; wr_addr = 11; wr_data = 16'hC0DE; end
            if (k == 37) rd_req = 1'b0;
            #4;
            if (k <= 17 && rd_valid) nvalid++;
            if (k == 16) check("t4_read8_oe_n", 32'(sram_oe_n), 0);
            if (k == 17) check("t4_wr_after8", 32'(sram_dq_oe), 1);
            if (k == 17) check("t4_wr_addr", 32'(sram_addr), 10);
            if (k == 19) check("t4_turn_ce_n", 32'(sram_ce_n), 1);
            if (k == 20) check("t4_resume_oe_n", 32'(sram_oe_n), 0);
            if (k == 35) check("t4_streak_reset_rd", 32'(sram_oe_n), 0);
            if (k == 36) check("t4_second_wr", 32'(sram_dq_oe), 1);
            if (k == 36) check("t4_second_addr", 32'(sram_addr), 11);
            if (k == 39) check("t4_idle_ce_n", 32'(sram_ce_n), 1);
        end
        check("t4_reads_before_wr", 32'(nvalid), 8);
        check("t4_mem10", 32'(sram_mem[10]), 32'hBEEF);
        check("t4_mem11", 32'(sram_mem[11]), 32'hC0DE);

        // Second write request while the buffer is occupied must be ignored.
        cyc(); wr_req = 1'b1; wr_addr = 12; wr_data = 16'h1111;
        cyc(); wr_addr = 13; wr_data = 16'h2222;
        cyc(); wr_req = 1'b0; #4;
        check("t5_addr", 32'(sram_addr), 12);
        check("t5_dq", 32'(sram_dq_o), 32'h1111);
        repeat (4) cyc();
        check("t5_mem12", 32'(sram_mem[12]), 32'h1111);
        check("t5_mem13", 32'(sram_mem[13]), 32'h100D);

        // Reset asserted during the first write cycle aborts the write.
        cyc(); wr_req = 1'b1; wr_addr = 14; wr_data = 16'h7777;
        cyc(); wr_req = 1'b0;
        cyc(); rst_n = 1'b0; #1;
        check("t6_we_n_async", 32'(sram_we_n), 1);
        check("t6_ce_n_async", 32'(sram_ce_n), 1);
        check("t6_dq_oe_async", 32'(sram_dq_oe), 0);
        cyc();
        cyc(); rst_n = 1'b1; #4;
        check("t6_wr_ready", 32'(wr_ready), 1);
        check("t6_rd_valid", 32'(rd_valid), 0);
        repeat (3) cyc();
        #4;
        check("t6_no_replay", 32'(sram_ce_n), 1);
        check("t6_mem14", 32'(sram_mem[14]), 32'h100E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
